peak_detect_topn: RTL and testbench

- Parametrised successor to the single-slot fast peak detector.
- Tracks the N largest samples of a frame, with their sample indices, in a sorted register table with single-cycle insertion at full throughput.
- Supports a runtime search window, an amplitude threshold and a minimum peak separation.
- At frame end the table is copied into a result bank and streamed out highest-first over a valid/ready port while the next frame is already being searched. Sits between the sample pipeline and the readback/host interface.

---
 rtl/peak_detect_topn.sv | 221 ++++++++++++++++++++++
 tb/tb_peak_detect_topn.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/peak_detect_topn.sv
// Top-N peak detector: keeps the N largest eligible samples of a frame in a sorted
// table and streams the previous frame's results highest-first over valid/ready.
module peak_detect_topn #(
    parameter int unsigned VALUE_WIDTH = 16,
    parameter int unsigned INDEX_WIDTH = 12,
    parameter int unsigned NUM_PEAKS   = 3,
    parameter int unsigned MIN_SEP     = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    input  logic                   s_last,
    input  logic [VALUE_WIDTH-1:0] s_value,
    input  logic [VALUE_WIDTH-1:0] threshold,
    input  logic [INDEX_WIDTH-1:0] win_lo,
    input  logic [INDEX_WIDTH-1:0] win_hi,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [VALUE_WIDTH-1:0] m_value,
    output logic [INDEX_WIDTH-1:0] m_index,
    output logic [3:0]             m_rank,
    output logic                   m_last,
    output logic [4:0]             peak_count,
    output logic                   frame_done,
    output logic                   overrun
);
    localparam int unsigned HIST_W = (MIN_SEP > 0) ? MIN_SEP : 1;
    localparam int unsigned RANK_W = 4;
    localparam int unsigned CNT_W  = 5;

    // Working table: entries are kept sorted, occupied entries form a prefix
    logic [VALUE_WIDTH-1:0] tbl_val_q [NUM_PEAKS];
    logic [VALUE_WIDTH-1:0] tbl_val_d [NUM_PEAKS];
    logic [INDEX_WIDTH-1:0] tbl_idx_q [NUM_PEAKS];
    logic [INDEX_WIDTH-1:0] tbl_idx_d [NUM_PEAKS];
    logic [NUM_PEAKS-1:0]   tbl_vld_q, tbl_vld_d;

    logic [VALUE_WIDTH-1:0] upd_val [NUM_PEAKS];
    logic [INDEX_WIDTH-1:0] upd_idx [NUM_PEAKS];
    logic [NUM_PEAKS-1:0]   upd_vld;
    logic [CNT_W-1:0]       upd_cnt;

    logic [VALUE_WIDTH-1:0] res_val_q [NUM_PEAKS];
    logic [VALUE_WIDTH-1:0] res_val_d [NUM_PEAKS];
    logic [INDEX_WIDTH-1:0] res_idx_q [NUM_PEAKS];
    logic [INDEX_WIDTH-1:0] res_idx_d [NUM_PEAKS];

    logic [INDEX_WIDTH-1:0] idx_q, idx_d;
    logic [HIST_W-1:0]      hist_q, hist_d;

    logic                   m_valid_q, m_valid_d;
    logic [VALUE_WIDTH-1:0] m_value_q, m_value_d;
    logic [INDEX_WIDTH-1:0] m_index_q, m_index_d;
    logic [RANK_W-1:0]      m_rank_q, m_rank_d;
    logic                   m_last_q, m_last_d;
    logic [CNT_W-1:0]       peak_count_q, peak_count_d;
    logic                   frame_done_q, frame_done_d;
    logic                   overrun_q, overrun_d;

    logic                   frame_end;
    logic                   eligible;
    logic                   inserted;
    logic [NUM_PEAKS-1:0]   ge;
    logic [RANK_W-1:0]      nxt_rank;

    assign frame_end = s_valid && s_last;

    // Eligibility, insertion into the sorted table and index/history tracking
    always_comb begin
        eligible = s_valid
                && (idx_q >= win_lo) && (idx_q <= win_hi)
                && (s_value >= threshold)
                && !((MIN_SEP > 0) && (|hist_q));
        for (int i = 0; i < NUM_PEAKS; i++) begin
            ge[i] = tbl_vld_q[i] && (tbl_val_q[i] >= s_value);
        end
        inserted = eligible && !ge[NUM_PEAKS-1];

        upd_val = tbl_val_q;
        upd_idx = tbl_idx_q;
        upd_vld = tbl_vld_q;
        if (inserted) begin
            if (!ge[0]) begin
                upd_val[0] = s_value;
                upd_idx[0] = idx_q;
                upd_vld[0] = 1'b1;
            end
            for (int i = 1; i < NUM_PEAKS; i++) begin
                if (!ge[i]) begin
                    if (ge[i-1]) begin
                        upd_val[i] = s_value;
                        upd_idx[i] = idx_q;
                        upd_vld[i] = 1'b1;
                    end else begin
                        upd_val[i] = tbl_val_q[i-1];
                        upd_idx[i] = tbl_idx_q[i-1];
                        upd_vld[i] = tbl_vld_q[i-1];
                    end
                end
            end
        end

        upd_cnt = '0;
        for (int i = 0; i < NUM_PEAKS; i++) begin
            upd_cnt = upd_cnt + CNT_W'(upd_vld[i]);
        end

        idx_d     = idx_q;
        hist_d    = hist_q;
        tbl_val_d = upd_val;
        tbl_idx_d = upd_idx;
        tbl_vld_d = upd_vld;
        if (s_valid) begin
            idx_d  = idx_q + INDEX_WIDTH'(1);
            hist_d = (hist_q << 1) | HIST_W'(inserted);
        end
        if (MIN_SEP == 0) begin
            hist_d = '0;
        end
        if (frame_end) begin
            idx_d  = '0;
            hist_d = '0;
            for (int i = 0; i < NUM_PEAKS; i++) begin
                tbl_val_d[i] = '0;
                tbl_idx_d[i] = '0;
            end
            tbl_vld_d = '0;
        end
    end

    // Result bank load and highest-first readout
    always_comb begin
        res_val_d    = res_val_q;
        res_idx_d    = res_idx_q;
        m_valid_d    = m_valid_q;
        m_value_d    = m_value_q;
        m_index_d    = m_index_q;
        m_rank_d     = m_rank_q;
        m_last_d     = m_last_q;
        peak_count_d = peak_count_q;
        frame_done_d = 1'b0;
        overrun_d    = 1'b0;
        nxt_rank     = m_rank_q + RANK_W'(1);

        if (frame_end) begin
            res_val_d    = upd_val;
            res_idx_d    = upd_idx;
            peak_count_d = upd_cnt;
            frame_done_d = 1'b1;
            // Accepting the final entry on this edge means the readout finished cleanly
            overrun_d    = m_valid_q && !(m_ready && m_last_q);
            m_valid_d    = (upd_cnt != '0);
            m_rank_d     = '0;
            m_value_d    = upd_val[0];
            m_index_d    = upd_idx[0];
            m_last_d     = (upd_cnt == CNT_W'(1));
        end else if (m_valid_q && m_ready) begin
            if (m_last_q) begin
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
            end else begin
                m_rank_d = nxt_rank;
                for (int i = 0; i < NUM_PEAKS; i++) begin
                    if (RANK_W'(i) == nxt_rank) begin
                        m_value_d = res_val_q[i];
                        m_index_d = res_idx_q[i];
                    end
                end
                m_last_d = (({1'b0, nxt_rank} + CNT_W'(1)) == peak_count_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q     <= '0;
            hist_q    <= '0;
            tbl_vld_q <= '0;
            for (int i = 0; i < NUM_PEAKS; i++) begin
                tbl_val_q[i] <= '0;
                tbl_idx_q[i] <= '0;
                res_val_q[i] <= '0;
                res_idx_q[i] <= '0;
            end
            m_valid_q    <= 1'b0;
            m_value_q    <= '0;
            m_index_q    <= '0;
            m_rank_q     <= '0;
            m_last_q     <= 1'b0;
            peak_count_q <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            hist_q       <= hist_d;
            tbl_val_q    <= tbl_val_d;
            tbl_idx_q    <= tbl_idx_d;
            tbl_vld_q    <= tbl_vld_d;
            res_val_q    <= res_val_d;
            res_idx_q    <= res_idx_d;
            m_valid_q    <= m_valid_d;
            m_value_q    <= m_value_d;
            m_index_q    <= m_index_d;
            m_rank_q     <= m_rank_d;
            m_last_q     <= m_last_d;
            peak_count_q <= peak_count_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_value    = m_value_q;
    assign m_index    = m_index_q;
    assign m_rank     = m_rank_q;
    assign m_last     = m_last_q;
    assign peak_count = peak_count_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_peak_detect_topn.sv
// Bench for peak_detect_topn: directed and random frames compared every cycle
// against a queue-based reference model of the top-N table and result readout.
module tb_peak_detect_topn;
    localparam int unsigned VW = 16;
    localparam int unsigned IW = 12;
    localparam int unsigned NP = 3;
    localparam int unsigned MS = 1;

    logic          clk;
    logic          reset;
    logic          s_valid;
    logic          s_last;
    logic [VW-1:0] s_value;
    logic [VW-1:0] threshold;
    logic [IW-1:0] win_lo;
    logic [IW-1:0] win_hi;
    logic          m_valid;
    logic          m_ready;
    logic [VW-1:0] m_value;
    logic [IW-1:0] m_index;
    logic [3:0]    m_rank;
    logic          m_last;
    logic [4:0]    peak_count;
    logic          frame_done;
    logic          overrun;

    peak_detect_topn #(
        .VALUE_WIDTH(VW), .INDEX_WIDTH(IW), .NUM_PEAKS(NP), .MIN_SEP(MS)
    ) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_last(s_last),
        .s_value(s_value), .threshold(threshold), .win_lo(win_lo), .win_hi(win_hi),
        .m_valid(m_valid), .m_ready(m_ready), .m_value(m_value), .m_index(m_index),
        .m_rank(m_rank), .m_last(m_last), .peak_count(peak_count),
        .frame_done(frame_done), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int val;
        int idx;
    } ent_t;

    // Reference model state
    ent_t tbl[$];
    ent_t bank[$];
    bit   hist[$];
    int   mdl_idx;
    bit   e_valid, e_fd, e_ov;
    int   e_rank;

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;
    int pat_i = 0;
    bit ovr_seen = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("m_valid", 32'(m_valid), 32'(e_valid));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        chk("overrun", 32'(overrun), 32'(e_ov));
        chk("peak_count", 32'(peak_count), 32'(bank.size()));
        if (e_valid) begin
            chk("m_value", 32'(m_value), 32'(bank[e_rank].val));
            chk("m_index", 32'(m_index), 32'(bank[e_rank].idx));
            chk("m_rank", 32'(m_rank), 32'(e_rank));
            chk("m_last", 32'(m_last), 32'(e_rank == bank.size() - 1));
        end
    endtask

    // One clock: pick m_ready, advance the model from the current inputs, then compare
    task automatic step();
        bit fe, elig, ins, supp;
        int p;
        bit pat[5] = '{1, 0, 0, 1, 1};
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ($urandom_range(0, 3) != 0);
            2:       begin m_ready = pat[pat_i % 5]; pat_i++; end
            default: m_ready = 1'b0;
        endcase
        if (reset) begin
            tbl.delete(); bank.delete(); hist.delete();
            mdl_idx = 0; e_valid = 0; e_rank = 0; e_fd = 0; e_ov = 0;
        end else begin
            fe  = s_valid && s_last;
            ins = 0;
            if (s_valid) begin
                supp = 0;
                foreach (hist[k]) if (hist[k]) supp = 1;
                elig = (mdl_idx >= int'(win_lo)) && (mdl_idx <= int'(win_hi))
                    && (s_value >= threshold) && !supp;
                if (elig) begin
                    p = 0;
                    foreach (tbl[k]) if (tbl[k].val >= int'(s_value)) p++;
                    if (p < int'(NP)) begin
                        tbl.insert(p, '{int'(s_value), mdl_idx});
                        if (tbl.size() > int'(NP)) void'(tbl.pop_back());
                        ins = 1;
                    end
                end
                if (MS > 0) begin
                    hist.push_front(ins);
                    if (hist.size() > int'(MS)) void'(hist.pop_back());
                end
                mdl_idx = (mdl_idx + 1) % (1 << IW);
            end
            e_fd = 0;
            e_ov = 0;
            if (fe) begin
                e_ov = e_valid && !(m_ready && (e_rank == bank.size() - 1));
                bank = tbl;
                tbl.delete(); hist.delete();
                mdl_idx = 0;
                e_fd = 1;
                e_valid = (bank.size() > 0);
                e_rank = 0;
            end else if (e_valid && m_ready) begin
                if (e_rank == bank.size() - 1) e_valid = 0;
                else e_rank++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        if (e_ov) ovr_seen = 1;
    endtask

    task automatic drive(input bit v, input bit l, input int val);
        s_valid = v;
        s_last  = l;
        s_value = val[VW-1:0];
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0);
    endtask

    task automatic send_frame(input int n, input int vals[8]);
        for (int i = 0; i < n; i++) drive(1, i == n - 1, vals[i]);
    endtask

    initial begin
        reset = 1; s_valid = 0; s_last = 0; s_value = '0;
        threshold = '0; win_lo = '0; win_hi = 12'd4095; m_ready = 1;
        step(); step();
        reset = 0;
        idle(2);

        send_frame(5, '{5, 9, 2, 9, 7, 0, 0, 0});
        idle(5);
        send_frame(5, '{4, 8, 6, 3, 5, 0, 0, 0});
        idle(5);
        threshold = 16'd10; win_lo = 12'd2; win_hi = 12'd3;
        send_frame(5, '{20, 30, 11, 9, 50, 0, 0, 0});
        idle(3);
        win_lo = 12'd5; win_hi = 12'd2;
        send_frame(5, '{20, 30, 11, 9, 50, 0, 0, 0});
        idle(3);
        threshold = '0; win_lo = '0; win_hi = 12'd4095;

        ready_mode = 2; pat_i = 0;
        send_frame(7, '{3, 9, 1, 8, 6, 2, 7, 0});
        idle(8);

        // Second frame ends while the first readout is stalled
        ready_mode = 3;
        send_frame(3, '{7, 1, 5, 0, 0, 0, 0, 0});
        idle(2);
        send_frame(3, '{2, 0, 9, 0, 0, 0, 0, 0});
        chk("overrun_seen", 32'(ovr_seen), 32'd1);
        ready_mode = 0;
        idle(4);
        send_frame(3, '{6, 0, 4, 0, 0, 0, 0, 0});
        send_frame(3, '{1, 0, 8, 0, 0, 0, 0, 0});
        send_frame(5, '{3, 0, 5, 0, 2, 0, 0, 0});
        idle(5);

        send_frame(2, '{40, 50, 0, 0, 0, 0, 0, 0});
        s_valid = 1; s_last = 0; s_value = 16'd60;
        reset = 1;
        step();
        reset = 0;
        send_frame(3, '{1, 2, 3, 0, 0, 0, 0, 0});
        idle(5);

        for (int f = 0; f < 200; f++) begin
            int n;
            ready_mode = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 1));
            threshold = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 8)) : 16'd0;
            if ($urandom_range(0, 3) == 0) begin
                win_lo = 12'($urandom_range(0, 6));
                win_hi = 12'($urandom_range(0, 8));
            end else begin
                win_lo = '0;
                win_hi = 12'd4095;
            end
            n = int'($urandom_range(1, 8));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) drive(0, 0, 0);
                if ($urandom_range(0, 40) == 0) begin
                    reset = 1;
                    step();
                    reset = 0;
                end
                drive(1, i == n - 1, int'($urandom_range(0, 15)));
            end
            idle(int'($urandom_range(0, 4)));
        end
        ready_mode = 0;
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
